alu_mb_seq: RTL and testbench

Multi-byte operation sequencer for the shared 8-bit ALU (op/right/AI/BI/CI/BCD in; OUT/CO/V/Z/N/HC out, registered on clk when RDY).
- Accepts one N-byte request (add, sub, logic, shift-left, rotate-right), streams bytes into the ALU one per cycle, and chains carry from the ALU's registered CO into the next byte's CI.
- Collects result bytes, applies the decimal adjust, and reports combined C/V/Z/N flags.
- Sits between the ALU and 16/32-bit helpers (address/timer arithmetic).

---
 rtl/alu_mb_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_mb_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mb_seq.sv
// Multi-byte sequencer for the shared 8-bit ALU: streams up to NBYTES
// operand bytes through it, chains carry, decimal-adjusts and merges flags.
module alu_mb_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rdy,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic                  right,
    input  logic                  bcd,
    input  logic                  cin,
    input  logic [2:0]            len,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [8*NBYTES-1:0]   res,
    output logic                  c_out,
    output logic                  v_out,
    output logic                  z_out,
    output logic                  n_out,
    output logic [3:0]            alu_op,
    output logic                  alu_right,
    output logic                  alu_ci,
    output logic                  alu_bcd,
    output logic                  alu_rdy,
    output logic [7:0]            alu_ai,
    output logic [7:0]            alu_bi,
    input  logic [7:0]            alu_out,
    input  logic                  alu_co,
    input  logic                  alu_v,
    input  logic                  alu_z,
    input  logic                  alu_n,
    input  logic                  alu_hc
);

    localparam int W = 8 * NBYTES;
    localparam logic [W-1:0] BYTE_M = W'(8'hFF);
    localparam logic [2:0] NB = 3'(NBYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [3:0]     op_q;
    logic           right_q;
    logic           bcd_q;
    logic           cin_q;
    logic [2:0]     len_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2:0]     idx_q;
    logic [W-1:0]   buf_q;
    logic           err_q;
    logic [W-1:0]   res_q;
    logic           c_q;
    logic           v_q;
    logic           z_q;
    logic           n_q;

    logic           issuing;
    logic           bcd_eff;
    logic           legal;
    logic           arith;
    logic [2:0]     lm1;
    logic [2:0]     issue_pos;
    logic [2:0]     cap_k;
    logic [2:0]     cap_pos;
    logic [7:0]     ai_b;
    logic [7:0]     bi_b;
    logic [3:0]     adj_lo;
    logic [3:0]     adj_hi;
    logic           cap_en;
    logic [W-1:0]   buf_d;
    logic           n_d;
    logic           unused_alu;

    assign unused_alu = alu_z ^ alu_n;

    always_comb begin
        issuing   = (state_q == S_ISSUE);
        bcd_eff   = bcd_q & (op_q == 4'b0011);
        arith     = (op_q == 4'b0011) | (op_q == 4'b0111);
        legal     = ((op_q[1:0] == 2'b11) | (op_q[3:2] == 2'b11))
                  & (len_q != 3'd0) & (len_q <= NB)
                  & (~right_q | (op_q == 4'b1111));
        lm1       = len_q - 3'd1;
        // Rotate-right walks the operand from the top byte down
        issue_pos = right_q ? (lm1 - idx_q) : idx_q;
        ai_b      = 8'(a_q >> {issue_pos, 3'b000});
        bi_b      = 8'(b_q >> {issue_pos, 3'b000});
        cap_k     = (state_q == S_DRAIN) ? lm1 : (idx_q - 3'd1);
        cap_pos   = right_q ? (lm1 - cap_k) : cap_k;
        adj_lo    = alu_out[3:0] + ((bcd_eff & alu_hc) ? 4'd6 : 4'd0);
        adj_hi    = alu_out[7:4] + ((bcd_eff & alu_co) ? 4'd6 : 4'd0);
        cap_en    = (issuing & (idx_q != 3'd0)) | (state_q == S_DRAIN);
        buf_d     = buf_q;
        if (cap_en) begin
            buf_d = (buf_q & ~(BYTE_M << {cap_pos, 3'b000}))
                  | (W'({adj_hi, adj_lo}) << {cap_pos, 3'b000});
        end
        n_d       = 1'(buf_d >> {lm1, 3'b111});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            right_q <= 1'b0;
            bcd_q   <= 1'b0;
            cin_q   <= 1'b0;
            len_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else if (rdy) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= op;
                        right_q <= right;
                        bcd_q   <= bcd;
                        cin_q   <= cin;
                        len_q   <= len;
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= '0;
                        buf_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (legal) begin
                        state_q <= S_ISSUE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    buf_q <= buf_d;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == lm1) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    buf_q   <= buf_d;
                    res_q   <= buf_d;
                    c_q     <= alu_co;
                    v_q     <= alu_v & arith;
                    z_q     <= ~|buf_d;
                    n_q     <= n_d;
                    err_q   <= 1'b0;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE) | (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = done & err_q;
    assign res       = res_q;
    assign c_out     = c_q;
    assign v_out     = v_q;
    assign z_out     = z_q;
    assign n_out     = n_q;

    // Later bytes take the carry the ALU registered for the previous byte
    assign alu_rdy   = rdy & issuing;
    assign alu_op    = issuing ? op_q : 4'b0000;
    assign alu_right = issuing & right_q;
    assign alu_bcd   = issuing & bcd_eff;
    assign alu_ci    = issuing & ((idx_q == 3'd0) ? cin_q : alu_co);
    assign alu_ai    = issuing ? ai_b : 8'h00;
    assign alu_bi    = issuing ? bi_b : 8'h00;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Bench for alu_mb_seq: table of directed requests plus stall/reset
// sequences, against a small registered model of the 8-bit ALU.
module tb_alu_mb_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rdy = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic        right = 1'b0;
    logic        bcd = 1'b0;
    logic        cin = 1'b0;
    logic [2:0]  len = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] res;
    logic        c_out;
    logic        v_out;
    logic        z_out;
    logic        n_out;
    logic [3:0]  alu_op;
    logic        alu_right;
    logic        alu_ci;
    logic        alu_bcd;
    logic        alu_rdy;
    logic [7:0]  alu_ai;
    logic [7:0]  alu_bi;
    logic [7:0]  alu_out = '0;
    logic        alu_co = 1'b0;
    logic        alu_v = 1'b0;
    logic        alu_z = 1'b0;
    logic        alu_n = 1'b0;
    logic        alu_hc = 1'b0;

    int checks = 0;
    int failures = 0;
    int issue_cnt = 0;

    always #5 clk = ~clk;

    alu_mb_seq #(.NBYTES(4)) dut (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start),
        .op(op), .right(right), .bcd(bcd), .cin(cin), .len(len),
        .a(a), .b(b), .ready(ready), .done(done), .err(err),
        .res(res), .c_out(c_out), .v_out(v_out), .z_out(z_out),
        .n_out(n_out), .alu_op(alu_op), .alu_right(alu_right),
        .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_rdy(alu_rdy),
        .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_out(alu_out),
        .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z),
        .alu_n(alu_n), .alu_hc(alu_hc)
    );

    // Registered 8-bit ALU model
    logic [7:0] m_lg, m_bx, m_o;
    logic [4:0] m_lo, m_hi;
    logic       m_cin, m_hc;

    always @(posedge clk) begin
        if (alu_rdy) begin
            issue_cnt = issue_cnt + 1;
            case (alu_op[1:0])
                2'b00:   m_lg = alu_ai | alu_bi;
                2'b01:   m_lg = alu_ai & alu_bi;
                2'b10:   m_lg = alu_ai ^ alu_bi;
                default: m_lg = alu_ai;
            endcase
            if (alu_right) m_lg = {alu_ci, alu_ai[7:1]};
            case (alu_op[3:2])
                2'b00:   m_bx = alu_bi;
                2'b01:   m_bx = ~alu_bi;
                2'b10:   m_bx = m_lg;
                default: m_bx = 8'h00;
            endcase
            m_cin = (alu_right | (alu_op[3:2] == 2'b11)) ? 1'b0 : alu_ci;
            m_lo = {1'b0, m_lg[3:0]} + {1'b0, m_bx[3:0]} + {4'b0, m_cin};
            m_hc = m_lo[4] | (alu_bcd & (m_lo[3:1] >= 3'd5));
            m_hi = {1'b0, m_lg[7:4]} + {1'b0, m_bx[7:4]} + {4'b0, m_hc};
            m_o  = {m_hi[3:0], m_lo[3:0]};
            alu_out <= m_o;
            alu_hc  <= m_hc;
            alu_co  <= alu_right ? alu_ai[0]
                     : (m_hi[4] | (alu_bcd & (m_hi[3:1] >= 3'd5)));
            alu_v   <= (m_lg[7] == m_bx[7]) && (m_o[7] != m_lg[7]);
            alu_z   <= (m_o == 8'h00);
            alu_n   <= m_o[7];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  md;   // {right, bcd, cin}
        logic [2:0]  len;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  f;    // {err, c, v, z, n}
        int          cyc;
    } vec_t;

    vec_t vt[18];

    // Start one request and wait for done; optional stall window
    task automatic run(input string nm, input vec_t v,
                       input int st_at, input int st_len);
        int w;
        int cycles;
        w = 0;
        while (!ready && w < 20) begin
            tick();
            w++;
        end
        chk({nm, " ready"}, 64'(ready), 64'd1);
        op = v.op;
        {right, bcd, cin} = v.md;
        len = v.len;
        a = v.a;
        b = v.b;
        start = 1'b1;
        issue_cnt = 0;
        tick();
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            if (cycles == st_at) rdy = 1'b0;
            if (cycles == st_at + st_len) rdy = 1'b1;
            tick();
            cycles++;
            if (st_len > 0 && cycles == st_at + 1)
                chk({nm, " stall alu_rdy"}, 64'(alu_rdy), 64'd0);
        end
        rdy = 1'b1;
        chk({nm, " cycles"}, 64'(cycles), 64'(v.cyc));
        chk({nm, " err"}, 64'(err), 64'(v.f[4]));
        chk({nm, " issues"}, 64'(issue_cnt),
            v.f[4] ? 64'd0 : 64'(v.len));
        if (!v.f[4]) begin
            chk({nm, " res"}, 64'(res), 64'(v.res));
            chk({nm, " flags"}, 64'({c_out, v_out, z_out, n_out}),
                64'(v.f[3:0]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{4'b0011, 3'b000, 3'd2, 32'h12FF, 32'h0001, 32'h1300, 5'b00000, 5};
        vt[1]  = '{4'b0011, 3'b000, 3'd2, 32'h8000, 32'h8000, 32'h0000, 5'b01110, 5};
        vt[2]  = '{4'b0011, 3'b010, 3'd2, 32'h0999, 32'h0001, 32'h1000, 5'b00000, 5};
        vt[3]  = '{4'b0111, 3'b001, 3'd2, 32'h0000, 32'h0001, 32'hFFFF, 5'b00001, 5};
        vt[4]  = '{4'b1111, 3'b101, 3'd2, 32'h0001, 32'h0000, 32'h8000, 5'b01001, 5};
        vt[5]  = '{4'b1111, 3'b101, 3'd0, 32'h0001, 32'h0000, 32'h0000, 5'b10000, 2};
        vt[6]  = '{4'b0011, 3'b000, 3'd4, 32'hFFFFFFFF, 32'h1, 32'h0, 5'b01010, 7};
        vt[7]  = '{4'b1100, 3'b000, 3'd3, 32'h0F00F0, 32'h300005, 32'h3F00F5, 5'b00000, 6};
        vt[8]  = '{4'b1101, 3'b000, 3'd1, 32'h12345678, 32'hF0, 32'h70, 5'b00000, 4};
        vt[9]  = '{4'b1110, 3'b001, 3'd2, 32'hAAAA, 32'hAAAA, 32'h0, 5'b00010, 5};
        vt[10] = '{4'b1011, 3'b000, 3'd2, 32'h4081, 32'h0, 32'h8102, 5'b00001, 5};
        vt[11] = '{4'b1111, 3'b100, 3'd3, 32'h000003, 32'h0, 32'h000001, 5'b01000, 6};
        vt[12] = '{4'b0101, 3'b000, 3'd2, 32'h1, 32'h1, 32'h0, 5'b10000, 2};
        vt[13] = '{4'b0011, 3'b100, 3'd2, 32'h1, 32'h1, 32'h0, 5'b10000, 2};
        vt[14] = '{4'b0011, 3'b000, 3'd5, 32'h1, 32'h1, 32'h0, 5'b10000, 2};
        vt[15] = '{4'b0111, 3'b001, 3'd2, 32'h1234, 32'h0235, 32'h0FFF, 5'b01000, 5};
        vt[16] = '{4'b0011, 3'b010, 3'd1, 32'h25, 32'h38, 32'h63, 5'b00000, 4};
        vt[17] = '{4'b0111, 3'b011, 3'd1, 32'h10, 32'h01, 32'h0F, 5'b01000, 4};

        reset_n = 1'b0;
        tick();
        tick();
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst res", 64'(res), 64'd0);
        chk("rst flags", 64'({c_out, v_out, z_out, n_out}), 64'd0);
        chk("rst alu_rdy", 64'(alu_rdy), 64'd0);
        chk("rst alu_bus", 64'({alu_op, alu_ai, alu_bi, alu_ci}), 64'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            run($sformatf("v%0d", i), vt[i], 0, 0);
        end

        // 32-bit add with a 3-cycle stall in the middle of ISSUE
        run("stall", '{4'b0011, 3'b000, 3'd4, 32'h00FFFFFF, 32'h1,
                       32'h01000000, 5'b00000, 10}, 3, 3);
        rdy = 1'b0;
        tick();
        chk("stall done hold", 64'(done), 64'd1);
        rdy = 1'b1;
        tick();
        chk("stall done drop", 64'(done), 64'd0);
        chk("stall idle ready", 64'(ready), 64'd1);

        // Reset while bytes are in flight
        op = 4'b0011;
        {right, bcd, cin} = 3'b000;
        len = 3'd4;
        a = 32'h11111111;
        b = 32'h22222222;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid alu_rdy", 64'(alu_rdy), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid rst ready", 64'(ready), 64'd1);
        chk("mid rst done", 64'(done), 64'd0);
        chk("mid rst res", 64'(res), 64'd0);
        chk("mid rst alu_rdy", 64'(alu_rdy), 64'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (done) seen++;
            end
            chk("mid rst no done", 64'(seen), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
